// File: rtl/vout_frame_reader.sv
`default_nettype none
// ============================================================================
// Module      : vout_frame_reader
// Description : Video playback engine. Streams a stored frame from the frame
//               SRAM at one pixel per llc cycle and emits HREF/VREF/YUV
//               toward the video encoder. Host programs base and enable.
// Revision    : 1.0 - initial release
// ============================================================================
module vout_frame_reader #(
    parameter int H_ACTIVE = 720,
    parameter int H_TOTAL  = 864,
    parameter int V_ACTIVE = 288,
    parameter int V_TOTAL  = 312
) (
    input  logic        llc,
    input  logic        rst_n,
    input  logic        cfg_we,
    input  logic [1:0]  cfg_addr,
    input  logic [7:0]  cfg_data,
    input  logic [7:0]  sramData,
    output logic [18:0] sramAdr,
    output logic        sram_oe_n,
    output logic        HREF_o,
    output logic        VREF_o,
    output logic [7:0]  YUV_o,
    output logic        frame_done
);

    localparam int c_HW = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
    localparam int c_VW = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;

    localparam logic [c_HW-1:0] c_H_LAST     = c_HW'(H_TOTAL - 1);
    localparam logic [c_HW-1:0] c_H_ACT      = c_HW'(H_ACTIVE);
    localparam logic [c_HW-1:0] c_H_ACT_LAST = c_HW'(H_ACTIVE - 1);
    localparam logic [c_VW-1:0] c_V_LAST     = c_VW'(V_TOTAL - 1);
    localparam logic [c_VW-1:0] c_V_ACT      = c_VW'(V_ACTIVE);
    localparam logic [c_VW-1:0] c_V_ACT_LAST = c_VW'(V_ACTIVE - 1);

    localparam logic [7:0] c_BLANK_EVEN = 8'h80;
    localparam logic [7:0] c_BLANK_ODD  = 8'h10;

    // Host-visible registers and the per-frame base shadow
    logic [18:0]     r_base;
    logic            r_en;
    logic [18:0]     r_shadow;

    // Raster counters and read pointer
    logic [c_HW-1:0] r_hcnt;
    logic [c_VW-1:0] r_vcnt;
    logic [18:0]     r_rptr;

    // Pipeline stage 1 (address cycle flags) and stage 2 (data sampled)
    logic            r_act1, r_vref1, r_fd1, r_hb1;
    logic            r_act2, r_vref2, r_fd2, r_hb2;
    logic [7:0]      r_data;

    logic            w_wr_b0, w_wr_b1, w_wr_b2, w_wr_ctrl;
    logic [18:0]     w_base_next;
    logic            w_en_next;
    logic            w_en_rise;
    logic            w_run;
    logic            w_v_act;
    logic            w_active;
    logic            w_frame_start;
    logic            w_frame_wrap;
    logic            w_last_pix;
    logic            w_h_wrap;
    logic [18:0]     w_ptr;

    assign w_wr_b0   = cfg_we && (cfg_addr == 2'd0);
    assign w_wr_b1   = cfg_we && (cfg_addr == 2'd1);
    assign w_wr_b2   = cfg_we && (cfg_addr == 2'd2);
    assign w_wr_ctrl = cfg_we && (cfg_addr == 2'd3);

    // A same-cycle base write is visible to the shadow copy (write wins)
    assign w_base_next = {w_wr_b2 ? cfg_data[2:0] : r_base[18:16],
                          w_wr_b1 ? cfg_data      : r_base[15:8],
                          w_wr_b0 ? cfg_data      : r_base[7:0]};

    assign w_en_next = w_wr_ctrl ? cfg_data[0] : r_en;
    assign w_en_rise = w_en_next && !r_en;
    // Raster advances only when enabled now and not being disabled this edge
    assign w_run     = r_en && w_en_next;

    assign w_v_act       = (r_vcnt < c_V_ACT);
    assign w_active      = (r_hcnt < c_H_ACT) && w_v_act;
    assign w_h_wrap      = (r_hcnt == c_H_LAST);
    assign w_frame_start = (r_hcnt == '0) && (r_vcnt == '0);
    assign w_frame_wrap  = w_h_wrap && (r_vcnt == c_V_LAST);
    assign w_last_pix    = (r_hcnt == c_H_ACT_LAST) && (r_vcnt == c_V_ACT_LAST);
    // Pointer reloads from the shadow at frame start before the address issue
    assign w_ptr         = w_frame_start ? r_shadow : r_rptr;

    // Host register port and base shadow capture
    always_ff @(posedge llc or negedge rst_n) begin
        if (!rst_n) begin
            r_base   <= '0;
            r_en     <= 1'b0;
            r_shadow <= '0;
        end else begin
            r_base <= w_base_next;
            r_en   <= w_en_next;
            if (w_en_rise || (w_run && w_frame_wrap)) begin
                r_shadow <= w_base_next;
            end
        end
    end

    // Stage 0: raster counters, SRAM address issue and stage-1 flags
    always_ff @(posedge llc or negedge rst_n) begin
        if (!rst_n) begin
            r_hcnt    <= '0;
            r_vcnt    <= '0;
            r_rptr    <= '0;
            sramAdr   <= '0;
            sram_oe_n <= 1'b1;
            r_act1    <= 1'b0;
            r_vref1   <= 1'b0;
            r_fd1     <= 1'b0;
            r_hb1     <= 1'b0;
        end else if (!w_run) begin
            r_hcnt    <= '0;
            r_vcnt    <= '0;
            r_rptr    <= '0;
            sramAdr   <= '0;
            sram_oe_n <= 1'b1;
            r_act1    <= 1'b0;
            r_vref1   <= 1'b0;
            r_fd1     <= 1'b0;
            r_hb1     <= 1'b0;
        end else begin
            if (w_h_wrap) begin
                r_hcnt <= '0;
                r_vcnt <= (r_vcnt == c_V_LAST) ? '0 : r_vcnt + c_VW'(1);
            end else begin
                r_hcnt <= r_hcnt + c_HW'(1);
            end
            if (w_active) begin
                sramAdr <= w_ptr;
                r_rptr  <= w_ptr + 19'd1;
            end
            sram_oe_n <= !w_active;
            r_act1    <= w_active;
            r_vref1   <= w_v_act;
            r_fd1     <= w_last_pix;
            r_hb1     <= r_hcnt[0];
        end
    end

    // Stages 1 and 2: sample SRAM data, then drive the registered raster
    always_ff @(posedge llc or negedge rst_n) begin
        if (!rst_n) begin
            r_data     <= '0;
            r_act2     <= 1'b0;
            r_vref2    <= 1'b0;
            r_fd2      <= 1'b0;
            r_hb2      <= 1'b0;
            YUV_o      <= c_BLANK_EVEN;
            HREF_o     <= 1'b0;
            VREF_o     <= 1'b0;
            frame_done <= 1'b0;
        end else if (!w_run) begin
            r_data     <= '0;
            r_act2     <= 1'b0;
            r_vref2    <= 1'b0;
            r_fd2      <= 1'b0;
            r_hb2      <= 1'b0;
            YUV_o      <= c_BLANK_EVEN;
            HREF_o     <= 1'b0;
            VREF_o     <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            r_data     <= sramData;
            r_act2     <= r_act1;
            r_vref2    <= r_vref1;
            r_fd2      <= r_fd1;
            r_hb2      <= r_hb1;
            YUV_o      <= r_act2 ? r_data : (r_hb2 ? c_BLANK_ODD : c_BLANK_EVEN);
            HREF_o     <= r_act2;
            VREF_o     <= r_vref2;
            frame_done <= r_fd2;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vout_frame_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_vout_frame_reader
// Description : Directed self-checking bench for vout_frame_reader using a
//               small raster size and an asynchronous SRAM returning addr[7:0].
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vout_frame_reader;

    localparam int HA = 4;
    localparam int HT = 6;
    localparam int VA = 2;
    localparam int VT = 3;
    localparam int FR = HT * VT;

    logic        llc = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_we = 1'b0;
    logic [1:0]  cfg_addr = 2'd0;
    logic [7:0]  cfg_data = 8'd0;
    logic [7:0]  sramData;
    logic [18:0] sramAdr;
    logic        sram_oe_n;
    logic        HREF_o;
    logic        VREF_o;
    logic [7:0]  YUV_o;
    logic        frame_done;

    int n_chk  = 0;
    int n_fail = 0;

    vout_frame_reader #(
        .H_ACTIVE(HA), .H_TOTAL(HT), .V_ACTIVE(VA), .V_TOTAL(VT)
    ) dut (
        .llc(llc), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_data(cfg_data), .sramData(sramData), .sramAdr(sramAdr),
        .sram_oe_n(sram_oe_n), .HREF_o(HREF_o), .VREF_o(VREF_o),
        .YUV_o(YUV_o), .frame_done(frame_done)
    );

    // Asynchronous SRAM: data follows the registered address
    assign sramData = sramAdr[7:0];

    always #5 llc = ~llc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge llc);
        #1;
    endtask

    task automatic cfg(input logic [1:0] a, input logic [7:0] d);
        cfg_we   = 1'b1;
        cfg_addr = a;
        cfg_data = d;
        step();
        cfg_we   = 1'b0;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_adr"},  32'(sramAdr),   32'h0);
        chk({tag, "_oe"},   32'(sram_oe_n), 32'h1);
        chk({tag, "_href"}, 32'(HREF_o),    32'h0);
        chk({tag, "_vref"}, 32'(VREF_o),    32'h0);
        chk({tag, "_yuv"},  32'(YUV_o),     32'h80);
        chk({tag, "_fd"},   32'(frame_done), 32'h0);
    endtask

    // Advance one cycle and compare the raster against the frame model at position k
    task automatic frame_cycle(input logic [18:0] base, input int k);
        int p, h, v;
        logic act;
        logic [18:0] a;
        logic [7:0] yuv;
        step();
        p   = k % FR;
        h   = p % HT;
        v   = p / HT;
        act = (h < HA) && (v < VA);
        a   = base + 19'(v * HA + h);
        yuv = act ? a[7:0] : ((h % 2 == 1) ? 8'h10 : 8'h80);
        chk($sformatf("yuv_k%0d", k),  32'(YUV_o),      32'(yuv));
        chk($sformatf("href_k%0d", k), 32'(HREF_o),     32'(act));
        chk($sformatf("vref_k%0d", k), 32'(VREF_o),     32'(v < VA));
        chk($sformatf("fd_k%0d", k),   32'(frame_done), 32'((h == HA - 1) && (v == VA - 1)));
    endtask

    initial begin
        // Reset
        step();
        step();
        chk_idle("reset");
        rst_n = 1'b1;
        step();
        chk_idle("post_reset");

        // Register writes while disabled leave the raster idle
        cfg(2'd0, 8'h10);
        cfg(2'd1, 8'h00);
        cfg(2'd2, 8'h00);
        chk_idle("cfg_only");

        // Basic frame followed by the next frame from the same base
        cfg(2'd3, 8'h01);
        step();
        chk("first_adr", 32'(sramAdr), 32'h10);
        chk("first_oe",  32'(sram_oe_n), 32'h0);
        step();
        chk("pre_href", 32'(HREF_o), 32'h0);
        for (int k = 0; k < 2 * FR; k++) frame_cycle(19'h00010, k);

        // Mid-frame base write lands during line 1; current frame keeps old base
        for (int k = 2 * FR; k < 2 * FR + 3; k++) frame_cycle(19'h00010, k);
        cfg_we = 1'b1; cfg_addr = 2'd1; cfg_data = 8'h01;
        frame_cycle(19'h00010, 2 * FR + 3);
        cfg_we = 1'b1; cfg_addr = 2'd0; cfg_data = 8'h00;
        frame_cycle(19'h00010, 2 * FR + 4);
        cfg_we = 1'b0;
        for (int k = 2 * FR + 5; k < 3 * FR; k++) frame_cycle(19'h00010, k);
        for (int k = 3 * FR; k < 4 * FR; k++) frame_cycle(19'h00100, k);

        // Disable after two pixels, then restart from base at hcnt 0
        frame_cycle(19'h00100, 0);
        frame_cycle(19'h00100, 1);
        cfg(2'd3, 8'h00);
        chk_idle("disable");
        step();
        chk_idle("disable_hold");
        cfg(2'd3, 8'h01);
        step();
        chk("reen_adr", 32'(sramAdr), 32'h100);
        step();
        for (int k = 0; k < FR; k++) frame_cycle(19'h00100, k);

        // Address wrap-around at the top of the SRAM
        cfg(2'd3, 8'h00);
        cfg(2'd0, 8'hFE);
        cfg(2'd1, 8'hFF);
        cfg(2'd2, 8'h07);
        cfg(2'd3, 8'h01);
        step();
        chk("wrap_adr0", 32'(sramAdr), 32'h7FFFE);
        step();
        chk("wrap_adr1", 32'(sramAdr), 32'h7FFFF);
        frame_cycle(19'h7FFFE, 0);
        chk("wrap_adr2", 32'(sramAdr), 32'h00000);
        frame_cycle(19'h7FFFE, 1);
        chk("wrap_adr3", 32'(sramAdr), 32'h00001);
        for (int k = 2; k < FR + 2; k++) frame_cycle(19'h7FFFE, k);

        // Asynchronous reset between edges mid-frame
        #3;
        rst_n = 1'b0;
        #1;
        chk_idle("async_rst");
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk_idle($sformatf("after_rst%0d", i));
        end
        cfg(2'd3, 8'h01);
        step();
        chk("rst_base_adr", 32'(sramAdr), 32'h0);
        step();
        for (int k = 0; k < HT; k++) frame_cycle(19'h00000, k);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
